// File: rtl/iq_sched_pkg.sv
// Shared types and frame geometry for the RX IQ stream scheduler.
package iq_sched_pkg;

    typedef enum logic [1:0] {IDLE, PRIME, SEND} state_e;
    typedef enum logic {CH_RX1, CH_RX2} chan_e;

    localparam int BYTES_PER_COMP = 3;
    localparam int FRAME_BYTES    = 2 * BYTES_PER_COMP;
    localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);

endpackage

// File: rtl/rx_iq_stream_scheduler_if.sv
// Command, sample and byte-bus signals between the DDC/MCU side and the scheduler.
interface rx_iq_stream_scheduler_if #(
    parameter int SAMPLE_W = 24,
    parameter int FCNT_W   = 16
);
    logic                       stream_start;
    logic                       stream_stop;
    logic                       rx2_enable;
    logic                       rx1_valid;
    logic signed [SAMPLE_W-1:0] rx1_i;
    logic signed [SAMPLE_W-1:0] rx1_q;
    logic                       rx2_valid;
    logic signed [SAMPLE_W-1:0] rx2_i;
    logic signed [SAMPLE_W-1:0] rx2_q;
    logic                       byte_req;
    logic                       clear_flags;
    logic [7:0]                 byte_out;
    logic                       byte_valid;
    logic                       busy;
    logic                       rx1_overrun;
    logic                       rx2_overrun;
    logic                       underrun;
    logic [FCNT_W-1:0]          frame_count;

    modport master (
        output stream_start, stream_stop, rx2_enable,
        output rx1_valid, rx1_i, rx1_q, rx2_valid, rx2_i, rx2_q,
        output byte_req, clear_flags,
        input  byte_out, byte_valid, busy,
        input  rx1_overrun, rx2_overrun, underrun, frame_count
    );

    modport slave (
        input  stream_start, stream_stop, rx2_enable,
        input  rx1_valid, rx1_i, rx1_q, rx2_valid, rx2_i, rx2_q,
        input  byte_req, clear_flags,
        output byte_out, byte_valid, busy,
        output rx1_overrun, rx2_overrun, underrun, frame_count
    );

endinterface

// File: rtl/iq_hold_reg.sv
// One-entry sample holding register: a write always lands, a load hands out the old content.
module iq_hold_reg #(
    parameter int W = 48
) (
    input  logic         clk_in,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         wr,
    input  logic [W-1:0] wr_data,
    input  logic         ld,
    output logic         full,
    output logic [W-1:0] data,
    output logic         overrun
);

    logic         full_q, full_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (clr) begin
            full_d = 1'b0;
            data_d = '0;
        end else if (wr) begin
            full_d = 1'b1;
            data_d = wr_data;
        end else if (ld) begin
            full_d = 1'b0;
        end
    end

    // A write only counts as an overrun when the previous sample is not leaving this cycle.
    assign overrun = full_q & wr & ~ld & ~clr;
    assign full    = full_q;
    assign data    = data_q;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/rx_iq_stream_scheduler.sv
// Interleaves RX1/RX2 IQ samples into 6-byte Q/I frames served one byte per MCU strobe.
module rx_iq_stream_scheduler
    import iq_sched_pkg::*;
#(
    parameter int SAMPLE_W = 24,
    parameter int FCNT_W   = 16
) (
    input  logic                      clk_in,
    input  logic                      reset_n,
    rx_iq_stream_scheduler_if.slave   bus
);

    localparam int HOLD_W = 2 * SAMPLE_W;

    state_e              state_q, state_d;
    chan_e               ch_q, ch_d, next_ch, load_ch;
    logic                mode_q, mode_d;
    logic [2:0]          idx_q, idx_d;
    logic [HOLD_W-1:0]   shift_q, shift_d;
    logic                byte_valid_q, byte_valid_d;
    logic                rx1_overrun_q, rx1_overrun_d;
    logic                rx2_overrun_q, rx2_overrun_d;
    logic                underrun_q, underrun_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;

    logic                hold_clr, load_en, ld1, ld2, und_evt, sel_full;
    logic                full1, full2, ovr1_evt, ovr2_evt;
    logic [HOLD_W-1:0]   data1, data2, sel_data;

    iq_hold_reg #(.W(HOLD_W)) u_hold_rx1 (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .clr     (hold_clr),
        .wr      (bus.rx1_valid),
        .wr_data ({bus.rx1_q, bus.rx1_i}),
        .ld      (ld1),
        .full    (full1),
        .data    (data1),
        .overrun (ovr1_evt)
    );

    iq_hold_reg #(.W(HOLD_W)) u_hold_rx2 (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .clr     (hold_clr),
        .wr      (bus.rx2_valid),
        .wr_data ({bus.rx2_q, bus.rx2_i}),
        .ld      (ld2),
        .full    (full2),
        .data    (data2),
        .overrun (ovr2_evt)
    );

    // Dual mode alternates channels; single mode always returns to RX1.
    assign next_ch = (mode_q && ch_q == CH_RX1) ? CH_RX2 : CH_RX1;

    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        mode_d       = mode_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        byte_valid_d = byte_valid_q;
        fcnt_d       = fcnt_q;
        hold_clr     = 1'b0;
        load_en      = 1'b0;
        load_ch      = ch_q;
        ld1          = 1'b0;
        ld2          = 1'b0;
        und_evt      = 1'b0;

        if (bus.stream_start) begin
            state_d      = PRIME;
            mode_d       = bus.rx2_enable;
            ch_d         = CH_RX1;
            idx_d        = '0;
            shift_d      = '0;
            byte_valid_d = 1'b0;
        end else if (bus.stream_stop) begin
            state_d      = IDLE;
            idx_d        = '0;
            shift_d      = '0;
            byte_valid_d = 1'b0;
            hold_clr     = 1'b1;
        end else begin
            case (state_q)
                PRIME: begin
                    load_en = 1'b1;
                    state_d = SEND;
                end
                SEND: begin
                    if (bus.byte_req) begin
                        if (idx_q != LAST_IDX) begin
                            shift_d = {shift_q[HOLD_W-9:0], 8'h00};
                            idx_d   = idx_q + 3'd1;
                        end else begin
                            if (byte_valid_q) fcnt_d = fcnt_q + FCNT_W'(1);
                            ch_d    = next_ch;
                            load_ch = next_ch;
                            load_en = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end

        // An empty holding register still yields a full-length zero frame to keep byte alignment.
        sel_full = (load_ch == CH_RX1) ? full1 : full2;
        sel_data = (load_ch == CH_RX1) ? data1 : data2;
        if (load_en) begin
            idx_d = '0;
            if (sel_full) begin
                shift_d      = sel_data;
                byte_valid_d = 1'b1;
                ld1          = (load_ch == CH_RX1);
                ld2          = (load_ch == CH_RX2);
            end else begin
                shift_d      = '0;
                byte_valid_d = 1'b0;
                und_evt      = 1'b1;
            end
        end

        rx1_overrun_d = (rx1_overrun_q & ~bus.clear_flags) | ovr1_evt;
        rx2_overrun_d = (rx2_overrun_q & ~bus.clear_flags) | ovr2_evt;
        underrun_d    = (underrun_q & ~bus.clear_flags) | und_evt;
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            ch_q          <= CH_RX1;
            mode_q        <= 1'b0;
            idx_q         <= '0;
            shift_q       <= '0;
            byte_valid_q  <= 1'b0;
            rx1_overrun_q <= 1'b0;
            rx2_overrun_q <= 1'b0;
            underrun_q    <= 1'b0;
            fcnt_q        <= '0;
        end else begin
            state_q       <= state_d;
            ch_q          <= ch_d;
            mode_q        <= mode_d;
            idx_q         <= idx_d;
            shift_q       <= shift_d;
            byte_valid_q  <= byte_valid_d;
            rx1_overrun_q <= rx1_overrun_d;
            rx2_overrun_q <= rx2_overrun_d;
            underrun_q    <= underrun_d;
            fcnt_q        <= fcnt_d;
        end
    end

    assign bus.byte_out    = shift_q[HOLD_W-1 -: 8];
    assign bus.byte_valid  = byte_valid_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.rx1_overrun = rx1_overrun_q;
    assign bus.rx2_overrun = rx2_overrun_q;
    assign bus.underrun    = underrun_q;
    assign bus.frame_count = fcnt_q;

endmodule

// File: tb/tb_rx_iq_stream_scheduler.sv
// Bench for rx_iq_stream_scheduler: directed vector table, corner sequences, random vs. frame-queue model.
module tb_rx_iq_stream_scheduler;

    typedef struct packed {
        logic        start, stop, en2, req, clrf, v1, v2;
        logic [47:0] s1, s2;
    } in_t;

    typedef struct {
        in_t         in;
        logic [7:0]  eb;
        logic        ebv, ebusy;
        logic [15:0] efc;
        logic [2:0]  efl;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rx_iq_stream_scheduler_if bus ();
    rx_iq_stream_scheduler dut (.clk_in(clk), .reset_n(rst_n), .bus(bus));

    int nvec = 0;
    int nerr = 0;
    vec_t tbl[$];
    in_t  N, R, x;

    // Reference model: current frame as a queue of remaining bytes.
    int          m_ph;
    bit          m_dual, m_real, m_uevt;
    int          m_ch;
    logic [7:0]  m_q[$];
    bit          m_full[2], m_cons[2], m_ov[2];
    logic [47:0] m_dat[2];
    logic [15:0] m_fc;
    bit          m_und;

    localparam logic [47:0] F1 = {24'h123456, 24'hABCDEF};
    localparam logic [47:0] D1 = {24'h010203, 24'h040506};
    localparam logic [47:0] D2 = {24'h0A0B0C, 24'h0D0E0F};

    function automatic in_t mk(logic st, logic sp, logic en, logic rq, logic cf,
                               logic v1, logic [47:0] s1, logic v2, logic [47:0] s2);
        in_t r;
        r.start = st; r.stop = sp; r.en2 = en; r.req = rq; r.clrf = cf;
        r.v1 = v1; r.s1 = s1; r.v2 = v2; r.s2 = s2;
        return r;
    endfunction

    function automatic void add(in_t i, logic [7:0] eb, logic ebv, logic ebusy,
                                logic [15:0] efc, logic [2:0] efl);
        vec_t v;
        v.in = i; v.eb = eb; v.ebv = ebv; v.ebusy = ebusy; v.efc = efc; v.efl = efl;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] eb, input logic ebv,
                           input logic ebusy, input logic [15:0] efc, input logic [2:0] efl);
        chk({tag, ".byte_out"},    48'(bus.byte_out), 48'(eb));
        chk({tag, ".byte_valid"},  48'(bus.byte_valid), 48'(ebv));
        chk({tag, ".busy"},        48'(bus.busy), 48'(ebusy));
        chk({tag, ".frame_count"}, 48'(bus.frame_count), 48'(efc));
        chk({tag, ".flags"}, 48'({bus.rx1_overrun, bus.rx2_overrun, bus.underrun}), 48'(efl));
    endtask

    task automatic apply(input in_t a);
        bus.stream_start = a.start;
        bus.stream_stop  = a.stop;
        bus.rx2_enable   = a.en2;
        bus.byte_req     = a.req;
        bus.clear_flags  = a.clrf;
        bus.rx1_valid    = a.v1;
        bus.rx1_q        = $signed(a.s1[47:24]);
        bus.rx1_i        = $signed(a.s1[23:0]);
        bus.rx2_valid    = a.v2;
        bus.rx2_q        = $signed(a.s2[47:24]);
        bus.rx2_i        = $signed(a.s2[23:0]);
        @(posedge clk);
        #1;
    endtask

    task automatic m_load(input int ch);
        m_q.delete();
        for (int k = 0; k < 6; k++)
            m_q.push_back(m_full[ch] ? m_dat[ch][47-8*k -: 8] : 8'h00);
        m_real = m_full[ch];
        if (m_full[ch]) m_cons[ch] = 1'b1;
        else            m_uevt = 1'b1;
    endtask

    task automatic m_step(input in_t a);
        bit          clrh;
        bit          v[2];
        logic [47:0] s[2];
        clrh = 1'b0; m_uevt = 1'b0; m_cons[0] = 1'b0; m_cons[1] = 1'b0;
        v[0] = a.v1; v[1] = a.v2; s[0] = a.s1; s[1] = a.s2;
        if (a.start) begin
            m_ph = 1; m_dual = a.en2; m_ch = 0; m_q.delete(); m_real = 1'b0;
        end else if (a.stop) begin
            m_ph = 0; m_q.delete(); m_real = 1'b0; clrh = 1'b1;
        end else if (m_ph == 1) begin
            m_load(m_ch); m_ph = 2;
        end else if (m_ph == 2 && a.req) begin
            if (m_q.size() > 1) void'(m_q.pop_front());
            else begin
                if (m_real) m_fc = m_fc + 16'd1;
                m_ch = m_dual ? 1 - m_ch : 0;
                m_load(m_ch);
            end
        end
        if (a.clrf) begin m_ov[0] = 1'b0; m_ov[1] = 1'b0; m_und = 1'b0; end
        for (int n = 0; n < 2; n++) begin
            if (m_full[n] && v[n] && !m_cons[n] && !clrh) m_ov[n] = 1'b1;
            if (clrh)           m_full[n] = 1'b0;
            else if (v[n])      begin m_full[n] = 1'b1; m_dat[n] = s[n]; end
            else if (m_cons[n]) m_full[n] = 1'b0;
        end
        if (m_uevt) m_und = 1'b1;
    endtask

    initial begin
        N = mk(0, 0, 0, 0, 0, 0, '0, 0, '0);
        R = mk(0, 0, 0, 1, 0, 0, '0, 0, '0);

        // single mode
        add(mk(0, 0, 0, 0, 0, 1, F1, 0, '0), 8'h00, 0, 0, 16'd0, 3'b000);
        add(mk(1, 0, 0, 0, 0, 0, '0, 0, '0), 8'h00, 0, 1, 16'd0, 3'b000);
        add(N, 8'h12, 1, 1, 16'd0, 3'b000);
        add(R, 8'h34, 1, 1, 16'd0, 3'b000);
        add(R, 8'h56, 1, 1, 16'd0, 3'b000);
        add(R, 8'hAB, 1, 1, 16'd0, 3'b000);
        add(R, 8'hCD, 1, 1, 16'd0, 3'b000);
        add(R, 8'hEF, 1, 1, 16'd0, 3'b000);
        add(R, 8'h00, 0, 1, 16'd1, 3'b001);
        add(mk(0, 0, 0, 0, 1, 0, '0, 0, '0), 8'h00, 0, 1, 16'd1, 3'b000);
        add(mk(0, 1, 0, 0, 0, 0, '0, 0, '0), 8'h00, 0, 0, 16'd1, 3'b000);
        // dual mode
        add(mk(0, 0, 0, 0, 0, 1, D1, 1, D2), 8'h00, 0, 0, 16'd1, 3'b000);
        add(mk(1, 0, 1, 0, 0, 0, '0, 0, '0), 8'h00, 0, 1, 16'd1, 3'b000);
        add(N, 8'h01, 1, 1, 16'd1, 3'b000);
        for (int b = 2; b <= 6; b++) add(R, 8'(b), 1, 1, 16'd1, 3'b000);
        add(R, 8'h0A, 1, 1, 16'd2, 3'b000);
        for (int b = 'h0B; b <= 'h0F; b++) add(R, 8'(b), 1, 1, 16'd2, 3'b000);
        add(R, 8'h00, 0, 1, 16'd3, 3'b001);
        add(mk(0, 1, 0, 0, 1, 0, '0, 0, '0), 8'h00, 0, 0, 16'd3, 3'b000);
        // underrun
        add(mk(1, 0, 0, 0, 0, 0, '0, 0, '0), 8'h00, 0, 1, 16'd3, 3'b000);
        add(N, 8'h00, 0, 1, 16'd3, 3'b001);
        for (int b = 0; b < 6; b++) add(R, 8'h00, 0, 1, 16'd3, 3'b001);
        add(mk(0, 1, 0, 0, 1, 0, '0, 0, '0), 8'h00, 0, 0, 16'd3, 3'b000);

        bus.stream_start = 0; bus.stream_stop = 0; bus.rx2_enable = 0; bus.byte_req = 0;
        bus.clear_flags = 0; bus.rx1_valid = 0; bus.rx2_valid = 0;
        bus.rx1_i = '0; bus.rx1_q = '0; bus.rx2_i = '0; bus.rx2_q = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 8'h00, 0, 0, 16'd0, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < tbl.size(); k++) begin
            apply(tbl[k].in);
            chk_out($sformatf("tbl%0d", k), tbl[k].eb, tbl[k].ebv, tbl[k].ebusy, tbl[k].efc, tbl[k].efl);
        end

        // overrun, then a write coinciding with the frame-boundary load
        apply(mk(0, 0, 0, 0, 0, 1, {2{24'h111111}}, 0, '0));
        apply(mk(0, 0, 0, 0, 0, 1, {2{24'h222222}}, 0, '0));
        chk("ovr.set", 48'(bus.rx1_overrun), 48'd1);
        apply(mk(1, 0, 0, 0, 0, 0, '0, 0, '0));
        apply(N);
        chk_out("ovr.q0", 8'h22, 1, 1, 16'd3, 3'b100);
        apply(R); chk("ovr.q1", 48'(bus.byte_out), 48'h22);
        apply(R); chk("ovr.q2", 48'(bus.byte_out), 48'h22);
        apply(mk(0, 0, 0, 0, 1, 0, '0, 0, '0));
        chk("ovr.clr", 48'(bus.rx1_overrun), 48'd0);
        apply(mk(0, 0, 0, 0, 0, 1, {2{24'h444444}}, 0, '0));
        repeat (3) apply(R);
        apply(mk(0, 0, 0, 1, 0, 1, {2{24'h555555}}, 0, '0));
        chk_out("ovr.same", 8'h44, 1, 1, 16'd4, 3'b000);
        repeat (6) apply(R);
        chk_out("ovr.next", 8'h55, 1, 1, 16'd5, 3'b000);

        // stop beats byte_req; restart at RX1; restart mid-SEND keeps holding registers
        repeat (3) apply(R);
        apply(mk(0, 1, 0, 1, 0, 0, '0, 0, '0));
        chk_out("stop", 8'h00, 0, 0, 16'd5, 3'b000);
        apply(mk(0, 0, 0, 0, 0, 1, {2{24'h666666}}, 1, {2{24'h777777}}));
        apply(mk(1, 0, 1, 0, 0, 0, '0, 0, '0));
        chk("restart.busy", 48'(bus.busy), 48'd1);
        apply(N);
        chk_out("restart.rx1", 8'h66, 1, 1, 16'd5, 3'b000);
        apply(R);
        apply(mk(1, 0, 1, 0, 0, 0, '0, 0, '0));
        chk_out("resend.prime", 8'h00, 0, 1, 16'd5, 3'b000);
        apply(N);
        chk_out("resend.fill", 8'h00, 0, 1, 16'd5, 3'b001);
        repeat (6) apply(R);
        chk_out("resend.rx2", 8'h77, 1, 1, 16'd5, 3'b001);

        // asynchronous reset between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("areset", 8'h00, 0, 0, 16'd0, 3'b000);
        apply(N);
        @(negedge clk);
        rst_n = 1'b1;

        m_ph = 0; m_dual = 0; m_real = 0; m_ch = 0; m_q.delete(); m_fc = '0; m_und = 0;
        for (int n = 0; n < 2; n++) begin m_full[n] = 0; m_ov[n] = 0; m_dat[n] = '0; end
        for (int c = 0; c < 3000; c++) begin
            x.start = ($urandom_range(0, 39) == 0);
            x.stop  = ($urandom_range(0, 59) == 0);
            x.en2   = 1'($urandom);
            x.req   = 1'($urandom);
            x.clrf  = ($urandom_range(0, 29) == 0);
            x.v1    = ($urandom_range(0, 3) == 0);
            x.v2    = ($urandom_range(0, 3) == 0);
            x.s1    = {16'($urandom), 32'($urandom)};
            x.s2    = {16'($urandom), 32'($urandom)};
            m_step(x);
            apply(x);
            chk_out($sformatf("rnd%0d", c),
                    (m_ph == 2 && m_q.size() > 0) ? m_q[0] : 8'h00,
                    (m_ph == 2) ? m_real : 1'b0,
                    (m_ph != 0), m_fc, {m_ov[0], m_ov[1], m_und});
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
